imem_prog_loader: RTL and testbench
===================================

// Module: imem_prog_loader
// PURPOSE
//  Upstream of the fetch-decode stage. Receives a program byte-serially from the
//  chip pins and writes it into the core's instruction memory through a write port.
//  Halts the core while loading, verifies an XOR checksum, then pulses a core reset
//  so execution restarts at pc=0 with the new program.
// PARAMETERS
//  IMEM_SZ     16  instruction words to load per program
//  ADDR_W      4   imem address width (clog2 IMEM_SZ)
//  DATA_W      8   instruction/byte width
//  SYNC_STAGES 2   flops in each pin synchroniser (>=2)
// PORTS
//  clk        in   1       clock
//  rst        in   1       reset, synchronous, active-high
//  load_req   in   1       async pin; rising edge starts/restarts a load
//  data_strb  in   1       async pin; rising edge marks data_in valid
//  data_in    in   DATA_W  async pins; byte value, stable around data_strb edge
//  imem_we    out  1       imem write enable, 1-cycle pulse per byte
//  imem_waddr out  ADDR_W  imem write address
//  imem_wdata out  DATA_W  imem write data
//  core_halt  out  1       1 = core must hold pc/acc (stall)
//  core_rst   out  1       1-cycle pulse: core resets pc/acc/ir, keeps imem
//  load_done  out  1       sticky: last load passed checksum
//  load_err   out  1       sticky: last load failed checksum
//  load_cnt   out  ADDR_W+1 bytes accepted in current load (0..IMEM_SZ)
// BEHAVIOUR
//  - Reset: state RUN; all outputs 0; synchronisers, counter, checksum cleared.
//  - load_req, data_strb each pass SYNC_STAGES flops, then a rising-edge detector.
//    data_in passes the same depth so it aligns with the strobe edge.
//  - Strobe latency: imem_we asserted exactly SYNC_STAGES+1 cycles after the first
//    clk edge sampling data_strb high; high for 1 cycle; waddr/wdata valid with it.
//  - States:
//    RUN:   core_halt=0. Strobe edges ignored. load_req edge -> LOAD.
//    LOAD:  core_halt=1; entry clears load_cnt, csum, load_done, load_err.
//           Each strobe edge: write byte at waddr=load_cnt[ADDR_W-1:0],
//           csum^=byte, load_cnt++. When load_cnt reaches IMEM_SZ -> CHECK.
//    CHECK: core_halt=1, no writes. Next strobe edge = checksum byte:
//           ==csum -> load_done=1, core_rst pulse 1 cycle, then RUN
//           (core_halt drops same cycle core_rst drops).
//           !=csum -> load_err=1 -> ERR.
//    ERR:   core_halt=1, strobes ignored; only load_req edge (-> LOAD) or rst exits.
//  - load_req edge in LOAD/CHECK restarts the load (counter/csum cleared).
//  - load_req edge and strobe edge in same cycle: load_req wins, strobe dropped.
//  - Strobe edges closer than SYNC_STAGES+1 cycles apart are not guaranteed; the
//    sender keeps data_strb high and low >= SYNC_STAGES+1 cycles each.
//  - rst mid-load: immediate return to RUN, core_halt=0; imem holds partial data
//    until the core's own reset reinitialises it.
//  - load_cnt never exceeds IMEM_SZ; no address wrap within a load.
// TESTING
//  1 Reset, then load_req edge, 16 bytes 0x00..0x0F, checksum 0x00 -> 16 we pulses
//    addr 0..15 data=addr; core_rst one pulse; load_done=1, core_halt=0.
//  2 Same bytes, checksum 0x5A -> no core_rst; load_err=1, core_halt stays 1;
//    further strobes produce no imem_we.
//  3 In RUN, toggle data_strb 4 times -> imem_we never asserts, load_cnt=0.
//  4 Load 7 bytes, new load_req edge, then 16 bytes 0xFF + checksum 0x00 ->
//    load_cnt restarts at 0, addr 0..15 written 0xFF, load_done=1.
//  5 rst asserted after byte 9 -> next cycle all outputs 0, state RUN.
//  6 Strobe edge in same cycle as load_req edge while in ERR -> state LOAD,
//    load_cnt=0, no write, load_err cleared.

Source files
------------

// File: rtl/imem_prog_loader.sv
// Byte-serial program loader: synchronises the loader pins, streams bytes into the
// instruction memory, verifies an XOR checksum and restarts the core on success.
module imem_prog_loader #(
    parameter int IMEM_SZ     = 16,
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic              data_strb,
    input  logic [DATA_W-1:0] data_in,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_halt,
    output logic              core_rst,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   load_cnt
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LOAD,
        ST_CHECK,
        ST_ERR
    } state_t;

    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(IMEM_SZ - 1);

    // ------------------------------------------------------------------
    // Pin synchronisers and rising-edge detectors
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] req_sync;
    logic [SYNC_STAGES-1:0] strb_sync;
    logic [DATA_W-1:0]      data_sync [SYNC_STAGES];
    logic                   req_prev;
    logic                   strb_prev;
    logic                   req_edge;
    logic                   strb_edge;
    logic [DATA_W-1:0]      data_q;

    // NOTE: sequential state is written with <= only, so every flop samples the
    // pre-edge value of its neighbour and the shift chain advances one stage per clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_sync  <= '0;
            strb_sync <= '0;
            // NOTE: the data synchroniser is a small flop chain, not a RAM, so it is
            // cleared with the rest of the pipeline to keep the reset state fully known.
            for (int i = 0; i < SYNC_STAGES; i++) begin
                data_sync[i] <= '0;
            end
            req_prev  <= 1'b0;
            strb_prev <= 1'b0;
            req_edge  <= 1'b0;
            strb_edge <= 1'b0;
            data_q    <= '0;
        end else begin
            req_sync     <= {req_sync[SYNC_STAGES-2:0], load_req};
            strb_sync    <= {strb_sync[SYNC_STAGES-2:0], data_strb};
            data_sync[0] <= data_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                data_sync[i] <= data_sync[i-1];
            end
            req_prev  <= req_sync[SYNC_STAGES-1];
            strb_prev <= strb_sync[SYNC_STAGES-1];
            req_edge  <= req_sync[SYNC_STAGES-1] & ~req_prev;
            strb_edge <= strb_sync[SYNC_STAGES-1] & ~strb_prev;
            // Byte travels the same depth as the strobe so it lines up with strb_edge.
            data_q    <= data_sync[SYNC_STAGES-1];
        end
    end

    // ------------------------------------------------------------------
    // Load control FSM
    // ------------------------------------------------------------------
    state_t            state, state_d;
    logic [ADDR_W:0]   cnt_d;
    logic [DATA_W-1:0] csum, csum_d;
    logic              we_d;
    logic [ADDR_W-1:0] waddr_d;
    logic [DATA_W-1:0] wdata_d;
    logic              halt_d;
    logic              crst_d;
    logic              done_d;
    logic              err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            load_cnt   <= '0;
            csum       <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            core_halt  <= 1'b0;
            core_rst   <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            state      <= state_d;
            load_cnt   <= cnt_d;
            csum       <= csum_d;
            imem_we    <= we_d;
            imem_waddr <= waddr_d;
            imem_wdata <= wdata_d;
            core_halt  <= halt_d;
            core_rst   <= crst_d;
            load_done  <= done_d;
            load_err   <= err_d;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_d = state;
        cnt_d   = load_cnt;
        csum_d  = csum;
        we_d    = 1'b0;
        waddr_d = imem_waddr;
        wdata_d = imem_wdata;
        crst_d  = 1'b0;
        done_d  = load_done;
        err_d   = load_err;

        if (req_edge) begin
            // A load request from any state (re)starts the load; a coincident strobe is dropped.
            state_d = ST_LOAD;
            cnt_d   = '0;
            csum_d  = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end else if (strb_edge) begin
            case (state)
                ST_LOAD: begin
                    we_d    = 1'b1;
                    waddr_d = load_cnt[ADDR_W-1:0];
                    wdata_d = data_q;
                    csum_d  = csum ^ data_q;
                    cnt_d   = load_cnt + 1'b1;
                    if (load_cnt == LAST_CNT) begin
                        state_d = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (data_q == csum) begin
                        done_d  = 1'b1;
                        crst_d  = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_ERR;
                    end
                end
                default: begin
                end
            endcase
        end

        // Halt stays up through the core_rst cycle so both drop together.
        halt_d = (state_d != ST_RUN) || crst_d;
    end

endmodule

// File: tb/tb_imem_prog_loader.sv
// Directed bench for imem_prog_loader: drives the async pins with slow handshakes
// and compares outputs against hand-computed values on the falling clock edge.
module tb_imem_prog_loader;

    localparam int IMEM_SZ = 16;
    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_req;
    logic              data_strb;
    logic [DATA_W-1:0] data_in;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [DATA_W-1:0] imem_wdata;
    logic              core_halt;
    logic              core_rst;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   load_cnt;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] log_addr[$];
    logic [DATA_W-1:0] log_data[$];
    int                rst_pulses = 0;
    logic              halt_at_rst = 1'b0;

    imem_prog_loader #(
        .IMEM_SZ(IMEM_SZ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst(rst), .load_req(load_req), .data_strb(data_strb),
        .data_in(data_in), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .core_halt(core_halt), .core_rst(core_rst),
        .load_done(load_done), .load_err(load_err), .load_cnt(load_cnt)
    );

    always #5 clk = ~clk;

    // Record every write and core reset pulse as seen between clock edges.
    always @(negedge clk) begin
        if (imem_we) begin
            log_addr.push_back(imem_waddr);
            log_data.push_back(imem_wdata);
        end
        if (core_rst) begin
            rst_pulses++;
            halt_at_rst = core_halt;
        end
    end

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        rst_pulses = 0;
    endtask

    task automatic send_byte(input logic [DATA_W-1:0] b);
        @(negedge clk);
        data_in   = b;
        data_strb = 1'b1;
        repeat (4) @(negedge clk);
        data_strb = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_req();
        @(negedge clk);
        load_req = 1'b1;
        repeat (4) @(negedge clk);
        load_req = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; load_req = 1'b0; data_strb = 1'b0; data_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({imem_we, imem_waddr, imem_wdata, core_halt, core_rst, load_done, load_err, load_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got we=%b addr=%h data=%h halt=%b crst=%b done=%b err=%b cnt=%0d, want all 0",
                     imem_we, imem_waddr, imem_wdata, core_halt, core_rst, load_done, load_err, load_cnt);
        end
    endtask

    task automatic test_run_ignore();
        clear_log();
        for (int i = 0; i < 4; i++) send_byte(8'(8'hA0 + i));
        checks++;
        if (log_addr.size() != 0) begin
            errors++;
            $display("FAIL run_no_write: got %0d writes, want 0", log_addr.size());
        end
        checks++;
        if (load_cnt !== 5'd0 || core_halt !== 1'b0) begin
            errors++;
            $display("FAIL run_idle: got cnt=%0d halt=%b, want cnt=0 halt=0", load_cnt, core_halt);
        end
    endtask

    task automatic check_log(input string name, input logic [DATA_W-1:0] fill, input bit use_fill);
        checks++;
        if (log_addr.size() != IMEM_SZ) begin
            errors++;
            $display("FAIL %s_write_count: got %0d, want %0d", name, log_addr.size(), IMEM_SZ);
        end else begin
            for (int i = 0; i < IMEM_SZ; i++) begin
                logic [DATA_W-1:0] exp_d;
                exp_d = use_fill ? fill : DATA_W'(i);
                checks++;
                if (log_addr[i] !== ADDR_W'(i) || log_data[i] !== exp_d) begin
                    errors++;
                    $display("FAIL %s_write%0d: got addr=%h data=%h, want addr=%h data=%h",
                             name, i, log_addr[i], log_data[i], ADDR_W'(i), exp_d);
                end
            end
        end
    endtask

    task automatic test_load_ok();
        clear_log();
        pulse_req();
        checks++;
        if (core_halt !== 1'b1 || load_cnt !== 5'd0) begin
            errors++;
            $display("FAIL load_entry: got halt=%b cnt=%0d, want halt=1 cnt=0", core_halt, load_cnt);
        end
        // First byte checks the strobe-to-write latency cycle by cycle.
        @(negedge clk);
        data_in   = 8'h00;
        data_strb = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (imem_we !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: got we=%b two cycles after sampling, want 0", imem_we);
        end
        @(negedge clk);
        checks++;
        if (imem_we !== 1'b1) begin
            errors++;
            $display("FAIL latency_exact: got we=%b three cycles after sampling, want 1", imem_we);
        end
        @(negedge clk);
        checks++;
        if (imem_we !== 1'b0) begin
            errors++;
            $display("FAIL we_one_cycle: got we=%b, want 0", imem_we);
        end
        data_strb = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 1; i < IMEM_SZ; i++) send_byte(8'(i));
        checks++;
        if (load_cnt !== 5'd16 || core_halt !== 1'b1 || rst_pulses != 0) begin
            errors++;
            $display("FAIL ok_pre_check: got cnt=%0d halt=%b crst=%0d, want cnt=16 halt=1 crst=0",
                     load_cnt, core_halt, rst_pulses);
        end
        send_byte(8'h00);
        check_log("ok", 8'h00, 1'b0);
        checks++;
        if (rst_pulses != 1 || halt_at_rst !== 1'b1) begin
            errors++;
            $display("FAIL ok_core_rst: got pulses=%0d halt_during=%b, want 1 and 1", rst_pulses, halt_at_rst);
        end
        checks++;
        if (load_done !== 1'b1 || load_err !== 1'b0 || core_halt !== 1'b0) begin
            errors++;
            $display("FAIL ok_final: got done=%b err=%b halt=%b, want 1 0 0", load_done, load_err, core_halt);
        end
    endtask

    task automatic test_load_bad();
        clear_log();
        pulse_req();
        checks++;
        if (load_done !== 1'b0 || core_halt !== 1'b1) begin
            errors++;
            $display("FAIL bad_entry: got done=%b halt=%b, want 0 1", load_done, core_halt);
        end
        for (int i = 0; i < IMEM_SZ; i++) send_byte(8'(i));
        send_byte(8'h5A);
        checks++;
        if (rst_pulses != 0 || load_err !== 1'b1 || load_done !== 1'b0 || core_halt !== 1'b1) begin
            errors++;
            $display("FAIL bad_final: got crst=%0d err=%b done=%b halt=%b, want 0 1 0 1",
                     rst_pulses, load_err, load_done, core_halt);
        end
        send_byte(8'h11);
        send_byte(8'h22);
        checks++;
        if (log_addr.size() != IMEM_SZ || load_err !== 1'b1) begin
            errors++;
            $display("FAIL err_ignores_strobe: got writes=%0d err=%b, want %0d 1", log_addr.size(), load_err, IMEM_SZ);
        end
    endtask

    task automatic test_same_cycle();
        clear_log();
        @(negedge clk);
        data_in   = 8'h33;
        load_req  = 1'b1;
        data_strb = 1'b1;
        repeat (4) @(negedge clk);
        load_req  = 1'b0;
        data_strb = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (load_cnt !== 5'd0 || log_addr.size() != 0 || load_err !== 1'b0 || core_halt !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle: got cnt=%0d writes=%0d err=%b halt=%b, want 0 0 0 1",
                     load_cnt, log_addr.size(), load_err, core_halt);
        end
        send_byte(8'h44);
        checks++;
        if (load_cnt !== 5'd1 || log_addr.size() != 1) begin
            errors++;
            $display("FAIL same_cycle_in_load: got cnt=%0d writes=%0d, want 1 1", load_cnt, log_addr.size());
        end else begin
            checks++;
            if (log_addr[0] !== 4'h0 || log_data[0] !== 8'h44) begin
                errors++;
                $display("FAIL same_cycle_first_write: got addr=%h data=%h, want 0 44", log_addr[0], log_data[0]);
            end
        end
    endtask

    task automatic test_restart();
        for (int i = 0; i < 7; i++) send_byte(8'(8'h80 + i));
        checks++;
        if (load_cnt !== 5'd8) begin
            errors++;
            $display("FAIL restart_partial: got cnt=%0d, want 8", load_cnt);
        end
        pulse_req();
        checks++;
        if (load_cnt !== 5'd0) begin
            errors++;
            $display("FAIL restart_cnt: got cnt=%0d, want 0", load_cnt);
        end
        clear_log();
        for (int i = 0; i < IMEM_SZ; i++) send_byte(8'hFF);
        send_byte(8'h00);
        check_log("restart", 8'hFF, 1'b1);
        checks++;
        if (load_done !== 1'b1 || rst_pulses != 1 || core_halt !== 1'b0) begin
            errors++;
            $display("FAIL restart_final: got done=%b crst=%0d halt=%b, want 1 1 0", load_done, rst_pulses, core_halt);
        end
    endtask

    task automatic test_rst_mid_load();
        pulse_req();
        for (int i = 0; i < 9; i++) send_byte(8'(8'h10 + i));
        checks++;
        if (load_cnt !== 5'd9 || core_halt !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre_rst: got cnt=%0d halt=%b, want 9 1", load_cnt, core_halt);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({imem_we, imem_waddr, imem_wdata, core_halt, core_rst, load_done, load_err, load_cnt} !== '0) begin
            errors++;
            $display("FAIL mid_rst_outputs: got we=%b addr=%h data=%h halt=%b crst=%b done=%b err=%b cnt=%0d, want all 0",
                     imem_we, imem_waddr, imem_wdata, core_halt, core_rst, load_done, load_err, load_cnt);
        end
        rst = 1'b0;
        clear_log();
        send_byte(8'h55);
        checks++;
        if (log_addr.size() != 0 || core_halt !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_run: got writes=%0d halt=%b, want 0 0", log_addr.size(), core_halt);
        end
    endtask

    initial begin
        test_reset();
        test_run_ignore();
        test_load_ok();
        test_load_bad();
        test_same_cycle();
        test_restart();
        test_rst_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
